spi_reg_bridge: RTL and testbench

//  SPI slave (mode 0, MSB first) that is the host access port of the Pak-DSP register file.

---
 rtl/spi_bridge_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 38 +++
 rtl/spi_reg_bridge.sv | 252 +++++++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// -----------------------------------------------------------------------------
// spi_bridge_pkg
// Shared definitions for the SPI register bridge:
//   state_e   - frame sequencing states of the bridge FSM
//   CMD_BITS  - length of the command byte {rw, addr}
//   RW_BIT    - position of the read/write flag inside the command byte
// -----------------------------------------------------------------------------
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_FETCH,
    DATA,
    WR_COMMIT,
    DONE
  } state_e;

  localparam int CMD_BITS = 8;
  localparam int RW_BIT   = 7;

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings one asynchronous pin into the clk domain through two flops and
// flags single-cycle rise/fall pulses on the synchronised level.
// A pin edge therefore becomes an action on the third clk edge after it.
// Ports:
//   clk     in   system clock
//   d_i     in   asynchronous pin
//   sync_o  out  synchronised level
//   rise_o  out  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  out  one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // The chain is deliberately not reset: it always tracks the pin, so a
  // reset in the middle of a frame cannot fabricate a cs_n fall and start
  // decoding the tail of an aborted frame.
  always_ff @(posedge clk) begin
    meta_q <= d_i;
    sync_q <= meta_q;
    prev_q <= sync_q;
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// -----------------------------------------------------------------------------
// spi_reg_bridge
// SPI slave (mode 0, MSB first) acting as host access port of the register
// file. A 24-bit frame {rw, addr[6:0], data[15:0]} becomes one register write
// (write_en strobe) or one register read (rdata shifted out on MISO).
// SPI pins are asynchronous and oversampled in the clk domain.
// Optional feature: define SPI_BRIDGE_AUTOINC_EN to allow bursts - while cs_n
// stays low, further 16-bit words go to addr+1, addr+2, ... (wrapping).
// Ports:
//   clk, srst            system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi   SPI inputs from the host (asynchronous)
//   spi_miso             read data to the host
//   spi_miso_oe          MISO enable, follows synchronised ~cs_n
//   addr                 register address to the memory map
//   write_en, wdata      one-cycle write strobe and its data
//   rdata                combinational read data for addr
//   frame_err            one-cycle pulse when cs_n rises mid-frame
// -----------------------------------------------------------------------------
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise;
  logic sclk_fall;
  logic sclk_sync;
  logic cs_sync;
  logic cs_rise;
  logic cs_fall;
  logic mosi_sync;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  state_e                state_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [DATA_WIDTH-1:0] tx_sh_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_frame_q;
  logic                  load_pend_q;
  logic                  write_en_q;
  logic                  frame_err_q;
  logic                  oe_q;
  logic [CMD_BITS-1:0]   cmd_word;

  sync_edge_det u_sclk_sync (
    .clk    (clk),
    .d_i    (spi_sclk),
    .sync_o (sclk_sync),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_det u_cs_sync (
    .clk    (clk),
    .d_i    (spi_cs_n),
    .sync_o (cs_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  sync_edge_det u_mosi_sync (
    .clk    (clk),
    .d_i    (spi_mosi),
    .sync_o (mosi_sync),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  // Shift register contents including the bit sampled on this sclk rise;
  // the command byte is complete in its low bits on the 8th rise.
  assign shreg_d  = {shreg_q[DATA_WIDTH-2:0], mosi_sync};
  assign cmd_word = shreg_d[CMD_BITS-1:0];

  // Frame sequencer. Strobes are cleared every cycle and set only on the
  // cycle that needs them, which keeps write_en and frame_err one clk wide.
  // An abort drops rd_frame_q and tx_sh_q so MISO goes quiet immediately.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      tx_sh_q     <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      addr_q      <= '0;
      rd_frame_q  <= 1'b0;
      load_pend_q <= 1'b0;
      write_en_q  <= 1'b0;
      frame_err_q <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      write_en_q  <= 1'b0;
      frame_err_q <= 1'b0;
      oe_q        <= ~cs_sync;

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q     <= CMD;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            tx_sh_q     <= '0;
            rd_frame_q  <= 1'b0;
            load_pend_q <= 1'b0;
          end
        end

        CMD: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else if (sclk_rise) begin
            shreg_q <= shreg_d;
            if (bit_cnt_q == CMD_LAST) begin
              bit_cnt_q <= '0;
              addr_q    <= cmd_word[ADDR_WIDTH-1:0];
              if (cmd_word[RW_BIT]) begin
                state_q <= DATA;
              end else begin
                rd_frame_q  <= 1'b1;
                load_pend_q <= 1'b1;
                state_q     <= RD_FETCH;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        // addr has already settled, so rdata is valid for this cycle.
        RD_FETCH: begin
          if (cs_rise) begin
            frame_err_q <= 1'b1;
            rd_frame_q  <= 1'b0;
            tx_sh_q     <= '0;
            state_q     <= IDLE;
          end else begin
            rdata_q <= rdata;
            state_q <= DATA;
          end
        end

        // The 16th rise wins over a coincident cs_n rise so a complete word
        // is never thrown away.
        DATA: begin
          if (sclk_rise && (bit_cnt_q == DATA_LAST)) begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= '0;
            if (!rd_frame_q) begin
              wdata_q    <= shreg_d;
              write_en_q <= 1'b1;
              state_q    <= cs_rise ? IDLE : WR_COMMIT;
            end else if (cs_rise) begin
              rd_frame_q <= 1'b0;
              tx_sh_q    <= '0;
              state_q    <= IDLE;
            end else begin
`ifdef SPI_BRIDGE_AUTOINC_EN
              addr_q      <= addr_q + 1'b1;
              load_pend_q <= 1'b1;
              state_q     <= RD_FETCH;
`else
              tx_sh_q     <= '0;
              state_q     <= DONE;
`endif
            end
          end else if (cs_rise) begin
            frame_err_q <= 1'b1;
            rd_frame_q  <= 1'b0;
            tx_sh_q     <= '0;
            state_q     <= IDLE;
          end else begin
            if (sclk_rise) begin
              shreg_q   <= shreg_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            // First fall after a fetch loads the word, later falls shift it.
            if (sclk_fall && rd_frame_q) begin
              if (load_pend_q) begin
                tx_sh_q     <= rdata_q;
                load_pend_q <= 1'b0;
              end else begin
                tx_sh_q <= {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
        end

        // Address advances only after the strobe so the write lands on the
        // address it was meant for.
        WR_COMMIT: begin
          if (cs_rise) begin
            state_q <= IDLE;
          end else begin
`ifdef SPI_BRIDGE_AUTOINC_EN
            addr_q  <= addr_q + 1'b1;
            state_q <= DATA;
`else
            state_q <= DONE;
`endif
          end
        end

        DONE: begin
          if (cs_rise) begin
            rd_frame_q <= 1'b0;
            tx_sh_q    <= '0;
            state_q    <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // The synchronised sclk level itself carries no information beyond its
  // edge pulses; it is folded into nothing functional.
  logic sclk_level_unused;
  assign sclk_level_unused = sclk_sync;

  assign addr        = addr_q;
  assign write_en    = write_en_q;
  assign wdata       = wdata_q;
  assign frame_err   = frame_err_q;
  assign spi_miso_oe = oe_q;
  assign spi_miso    = tx_sh_q[DATA_WIDTH-1] & rd_frame_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: drives SPI frames with 6-clk sclk phases
// and compares strobes, captured writes and MISO bits against hand values.
module tb_spi_reg_bridge;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [6:0]  addr;
  logic        write_en;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastRiseCyc = 0;
  logic [71:0] misoCap = '0;

  logic [6:0]  wrAddrQ[$];
  logic [15:0] wrDataQ[$];
  int          wrCycQ[$];
  int          errCount = 0;
  int          errRun = 0;
  int          lastErrWidth = 0;

  spi_reg_bridge dut (
    .clk         (clk),
    .srst        (srst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .addr        (addr),
    .write_en    (write_en),
    .wdata       (wdata),
    .rdata       (rdata),
    .frame_err   (frame_err)
  );

  // Register file model: one known word at 0x20, a pattern elsewhere.
  assign rdata = (addr == 7'h20) ? 16'hBEEF : (16'h1357 ^ {9'd0, addr});

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every write strobe and measures frame_err pulse widths.
  always @(negedge clk) begin
    if (write_en) begin
      wrAddrQ.push_back(addr);
      wrDataQ.push_back(wdata);
      wrCycQ.push_back(cyc);
    end
    if (frame_err) begin
      if (errRun == 0) errCount = errCount + 1;
      errRun = errRun + 1;
    end else if (errRun > 0) begin
      lastErrWidth = errRun;
      errRun = 0;
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected) else begin
      bad = bad + 1;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends nbits of bits, MSB first; MISO is sampled just before each rise.
  task automatic applyStimulus(input logic [71:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = bits[i];
      waitClk(HALF);
      misoCap = {misoCap[70:0], spi_miso};
      lastRiseCyc = cyc;
      spi_sclk = 1'b1;
      waitClk(HALF);
      spi_sclk = 1'b0;
    end
    waitClk(HALF);
  endtask

  task automatic csLow();
    spi_cs_n = 1'b0;
    waitClk(HALF);
  endtask

  task automatic csHigh();
    spi_cs_n = 1'b1;
    waitClk(8);
  endtask

  task automatic checkWrite(input string tag, input int idx, input logic [6:0] expAddr, input logic [15:0] expData);
    checkOutput({tag, "_present"}, 32'(wrAddrQ.size() > idx), 32'd1);
    if (wrAddrQ.size() > idx) begin
      checkOutput({tag, "_addr"}, 32'(wrAddrQ[idx]), 32'(expAddr));
      checkOutput({tag, "_data"}, 32'(wrDataQ[idx]), 32'(expData));
    end
  endtask

  initial begin
    int wr0;
    int err0;
    logic [23:0] frame;

    $display("[TB] start");
    waitClk(4);
    srst = 1'b0;
    waitClk(1);
    checkOutput("rst_write_en", 32'(write_en), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_wdata", 32'(wdata), 32'd0);
    checkOutput("rst_miso", 32'(spi_miso), 32'd0);
    checkOutput("rst_oe", 32'(spi_miso_oe), 32'd0);
    waitClk(4);

    // Single write 0x05 <- 0x1234
    wr0 = wrAddrQ.size();
    err0 = errCount;
    csLow();
    checkOutput("wr_oe_active", 32'(spi_miso_oe), 32'd1);
    misoCap = '0;
    applyStimulus({48'd0, 1'b1, 7'h05, 16'h1234}, 24);
    csHigh();
    checkOutput("wr_count", 32'(wrAddrQ.size() - wr0), 32'd1);
    checkWrite("wr05", wr0, 7'h05, 16'h1234);
    if (wrCycQ.size() > wr0)
      checkOutput("wr_latency", 32'(wrCycQ[wr0] - lastRiseCyc), 32'd3);
    checkOutput("wr_miso_quiet", misoCap[31:0], 32'd0);
    checkOutput("wr_oe_idle", 32'(spi_miso_oe), 32'd0);
    checkOutput("wr_no_err", 32'(errCount - err0), 32'd0);

    // Read 0x20, model returns 0xBEEF
    wr0 = wrAddrQ.size();
    csLow();
    misoCap = '0;
    applyStimulus({48'd0, 1'b0, 7'h20, 16'h0000}, 24);
    csHigh();
    checkOutput("rd_miso_data", 32'(misoCap[15:0]), 32'h0000_BEEF);
    checkOutput("rd_miso_cmd", 32'(misoCap[23:16]), 32'd0);
    checkOutput("rd_no_write", 32'(wrAddrQ.size() - wr0), 32'd0);
    checkOutput("rd_addr_hold", 32'(addr), 32'h20);

    // Abort after 12 bits, then a clean frame
    wr0 = wrAddrQ.size();
    err0 = errCount;
    frame = {1'b1, 7'h11, 16'hCAFE};
    csLow();
    applyStimulus(72'(frame[23:12]), 12);
    csHigh();
    checkOutput("abort_err_count", 32'(errCount - err0), 32'd1);
    checkOutput("abort_err_width", 32'(lastErrWidth), 32'd1);
    checkOutput("abort_no_write", 32'(wrAddrQ.size() - wr0), 32'd0);
    csLow();
    applyStimulus(72'(frame), 24);
    csHigh();
    checkOutput("after_abort_count", 32'(wrAddrQ.size() - wr0), 32'd1);
    checkWrite("after_abort", wr0, 7'h11, 16'hCAFE);
    checkOutput("after_abort_no_err", 32'(errCount - err0), 32'd1);

    // Burst of three words starting at 0x01
    wr0 = wrAddrQ.size();
    csLow();
    applyStimulus({16'd0, 1'b1, 7'h01, 16'hAAAA, 16'h5555, 16'h0F0F}, 56);
    csHigh();
`ifdef SPI_BRIDGE_AUTOINC_EN
    checkOutput("burst_count", 32'(wrAddrQ.size() - wr0), 32'd3);
    checkWrite("burst_w0", wr0, 7'h01, 16'hAAAA);
    checkWrite("burst_w1", wr0 + 1, 7'h02, 16'h5555);
    checkWrite("burst_w2", wr0 + 2, 7'h03, 16'h0F0F);
`else
    checkOutput("burst_count", 32'(wrAddrQ.size() - wr0), 32'd1);
    checkWrite("burst_w0", wr0, 7'h01, 16'hAAAA);
`endif

    // Burst crossing the top of the address space
    wr0 = wrAddrQ.size();
    csLow();
    applyStimulus({32'd0, 1'b1, 7'h7F, 16'h1111, 16'h2222}, 40);
    csHigh();
`ifdef SPI_BRIDGE_AUTOINC_EN
    checkOutput("wrap_count", 32'(wrAddrQ.size() - wr0), 32'd2);
    checkWrite("wrap_w0", wr0, 7'h7F, 16'h1111);
    checkWrite("wrap_w1", wr0 + 1, 7'h00, 16'h2222);
`else
    checkOutput("wrap_count", 32'(wrAddrQ.size() - wr0), 32'd1);
    checkWrite("wrap_w0", wr0, 7'h7F, 16'h1111);
`endif

    // srst after 10 bits of a write discards the frame
    wr0 = wrAddrQ.size();
    err0 = errCount;
    frame = {1'b1, 7'h33, 16'h4321};
    csLow();
    applyStimulus(72'(frame[23:14]), 10);
    srst = 1'b1;
    waitClk(1);
    srst = 1'b0;
    checkOutput("srst_write_en", 32'(write_en), 32'd0);
    checkOutput("srst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("srst_addr", 32'(addr), 32'd0);
    checkOutput("srst_wdata", 32'(wdata), 32'd0);
    checkOutput("srst_miso", 32'(spi_miso), 32'd0);
    checkOutput("srst_oe", 32'(spi_miso_oe), 32'd0);
    applyStimulus(72'(frame[13:0]), 14);
    csHigh();
    checkOutput("srst_no_write", 32'(wrAddrQ.size() - wr0), 32'd0);
    checkOutput("srst_no_err", 32'(errCount - err0), 32'd0);
    csLow();
    applyStimulus(72'(frame), 24);
    csHigh();
    checkOutput("post_srst_count", 32'(wrAddrQ.size() - wr0), 32'd1);
    checkWrite("post_srst", wr0, 7'h33, 16'h4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
